// File: rtl/usb_rx_deserializer_if.sv
// Line-side inputs and byte-side outputs of the USB receive deserializer.
interface usb_rx_deserializer_if;
  logic       crd;
  logic       add;
  logic       drop;
  logic       se0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_active;
  logic       rx_error;
  logic       stuff_err;
  logic       fifo_ovf;
  logic       fifo_udf;

  modport master (
    output crd, add, drop, se0,
    input  rx_data, rx_valid, rx_active, rx_error, stuff_err, fifo_ovf, fifo_udf
  );

  modport slave (
    input  crd, add, drop, se0,
    output rx_data, rx_valid, rx_active, rx_error, stuff_err, fifo_ovf, fifo_udf
  );
endinterface

// File: rtl/usb_rx_deserializer.sv
// Elastic bit FIFO absorbing CDR slips, followed by NRZI decode, SYNC hunt,
// bit-unstuffing and byte assembly.
module usb_rx_deserializer #(
  parameter int DEPTH     = 8,
  parameter int START_LVL = 4
) (
  input logic                  clock,
  input logic                  reset,
  usb_rx_deserializer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] START_C = (AW+1)'(START_LVL);

  typedef enum logic [1:0] {HUNT, DATA, EOP} state_e;

  // FIFO state
  logic [1:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, wp1;
  logic [AW:0]   occ_q, occ_d, free;
  logic          drain_q, drain_d;
  logic          pop, ovf_d, udf_d;
  logic [1:0]    nreq, nacc;
  logic [1:0]    ent_in, ent_out;

  // decoder state
  state_e      state_q, state_d;
  logic        prev_q, prev_d;
  logic [2:0]  ones_q, ones_d, bcnt_q, bcnt_d, zrun_q, zrun_d;
  logic [7:0]  sh_q, sh_d, data_q, data_d;
  logic        vld_q, vld_d, act_q, act_d, err_q, err_d, stf_q, stf_d, ovf_q, udf_q;
  logic        dec;

  assign ent_in  = {bus.se0, bus.crd};
  assign ent_out = mem_q[rptr_q];
  assign wp1     = wptr_q + AW'(1);

  always_comb begin
    if (bus.drop && !bus.add)      nreq = 2'd0;
    else if (bus.add && !bus.drop) nreq = 2'd2;
    else                           nreq = 2'd1;
  end

  // Popping frees a slot this cycle, so a full FIFO that is draining still
  // accepts one entry; the later half of an add pair is the one dropped.
  always_comb begin
    pop  = drain_q && (occ_q != '0);
    free = DEPTH_C - occ_q + {{AW{1'b0}}, pop};
    if ({{(AW-1){1'b0}}, nreq} <= free) nacc = nreq;
    else                                 nacc = free[1:0];
    ovf_d  = (nacc != nreq);
    occ_d  = occ_q + {{(AW-1){1'b0}}, nacc} - {{AW{1'b0}}, pop};
    wptr_d = wptr_q + AW'(nacc);
    rptr_d = rptr_q + AW'(pop);
    udf_d  = drain_q && (occ_q == '0);
    if (!drain_q) drain_d = (occ_q >= START_C);
    else          drain_d = (occ_q != '0);
  end

  always_ff @(posedge clock) begin
    if (nacc != 2'd0) mem_q[wptr_q] <= ent_in;
    if (nacc == 2'd2) mem_q[wp1]    <= ent_in;
  end

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    ones_d  = ones_q;
    bcnt_d  = bcnt_q;
    zrun_d  = zrun_q;
    sh_d    = sh_q;
    data_d  = data_q;
    vld_d   = 1'b0;
    err_d   = 1'b0;
    stf_d   = 1'b0;
    dec     = (ent_out[0] == prev_q);
    if (pop) begin
      if (ent_out[1]) begin
        prev_d = 1'b1;
        case (state_q)
          HUNT: zrun_d = '0;
          DATA: begin
            state_d = EOP;
            err_d   = (bcnt_q != '0);
            bcnt_d  = '0;
            ones_d  = '0;
          end
          default: ;
        endcase
      end else begin
        prev_d = ent_out[0];
        case (state_q)
          HUNT: begin
            if (dec) begin
              if (zrun_q >= 3'd5) begin
                state_d = DATA;
                ones_d  = 3'd1;
                bcnt_d  = '0;
              end
              zrun_d = '0;
            end else if (zrun_q != 3'd5) begin
              zrun_d = zrun_q + 3'd1;
            end
          end
          DATA: begin
            if (ones_q == 3'd6) begin
              if (dec) begin
                stf_d   = 1'b1;
                state_d = HUNT;
                zrun_d  = '0;
              end else begin
                ones_d = '0;
              end
            end else begin
              sh_d   = {dec, sh_q[7:1]};
              ones_d = dec ? ones_q + 3'd1 : 3'd0;
              bcnt_d = bcnt_q + 3'd1;
              if (bcnt_q == 3'd7) begin
                data_d = {dec, sh_q[7:1]};
                vld_d  = 1'b1;
              end
            end
          end
          default: begin
            state_d = HUNT;
            zrun_d  = dec ? 3'd0 : 3'd1;
          end
        endcase
      end
    end
    act_d = (state_d == DATA);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      occ_q   <= '0;
      drain_q <= 1'b0;
      state_q <= HUNT;
      prev_q  <= 1'b1;
      ones_q  <= '0;
      bcnt_q  <= '0;
      zrun_q  <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      vld_q   <= 1'b0;
      act_q   <= 1'b0;
      err_q   <= 1'b0;
      stf_q   <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      occ_q   <= occ_d;
      drain_q <= drain_d;
      state_q <= state_d;
      prev_q  <= prev_d;
      ones_q  <= ones_d;
      bcnt_q  <= bcnt_d;
      zrun_q  <= zrun_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      act_q   <= act_d;
      err_q   <= err_d;
      stf_q   <= stf_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  assign bus.rx_data   = data_q;
  assign bus.rx_valid  = vld_q;
  assign bus.rx_active = act_q;
  assign bus.rx_error  = err_q;
  assign bus.stuff_err = stf_q;
  assign bus.fifo_ovf  = ovf_q;
  assign bus.fifo_udf  = udf_q;
endmodule

// File: doc/usb_rx_deserializer.md
USB_RX_DESERIALIZER -- requirements
Module: usb_rx_deserializer

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- DEPTH, 8, elastic bit-FIFO entries; power of two, at least 4.
- START_LVL, 4, occupancy at which draining begins; between 1 and DEPTH-1.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clock, in, 1, clock.
- reset, in, 1, reset, synchronous, active-high.
- crd, in, 1, recovered line bit from the clock/data-recovery stage.
- add, in, 1, two line bits recovered this cycle.
- drop, in, 1, no line bit recovered this cycle.
- se0, in, 1, line SE0 flag, aligned with crd.
- rx_data, out, 8, assembled byte.
- rx_valid, out, 1, one-cycle strobe for rx_data.
- rx_active, out, 1, packet in progress.
- rx_error, out, 1, one-cycle strobe: packet ended on a partial byte.
- stuff_err, out, 1, one-cycle strobe: bit-stuff violation.
- fifo_ovf, out, 1, one-cycle strobe: input bits were discarded.
- fifo_udf, out, 1, one-cycle strobe: FIFO ran empty while draining.

Function
REQ-003 Each FIFO entry SHALL be the pair {se0, crd}.
REQ-004 Entries pushed per cycle SHALL be:
- drop=1, add=0: push 0 entries.
- add=1, drop=0: push 2 identical entries.
- otherwise (including add=1, drop=1): push 1 entry.
REQ-005 Occupancy SHALL update as next = occ + push - pop, where pop is decided from the pre-cycle occupancy.
REQ-006 An entry pushed in cycle t SHALL be poppable no earlier than cycle t+1.
REQ-007 Entries that would take occupancy above DEPTH SHALL be discarded, with the later entry of an add pair discarded first; fifo_ovf SHALL pulse in the following cycle.
REQ-008 The FIFO SHALL have two modes:
- PRIME (entered from reset): pop disabled; go to DRAIN when occ >= START_LVL.
- DRAIN: pop exactly one entry per cycle while occ >= 1.
REQ-009 If occ = 0 in DRAIN, the block SHALL return to PRIME, and fifo_udf SHALL pulse in the following cycle.
REQ-010 NRZI decode on each popped bit b SHALL be: decoded = 1 if b equals prev_line, else 0; then prev_line = b.
REQ-011 prev_line SHALL reset to 1 (J) and SHALL be set to 1 on every popped SE0 entry.
REQ-012 The decoder FSM SHALL have states HUNT, DATA and EOP, reset to HUNT.
REQ-013 In HUNT, a popped decoded 1 preceded by at least 5 consecutive decoded 0s SHALL move the FSM to DATA, assert rx_active, set ones_cnt to 1 and clear bit_cnt.
REQ-014 A popped SE0 entry in HUNT SHALL clear the zero run.
REQ-015 In DATA, bit-unstuffing SHALL work as follows:
- ones_cnt (0..6) counts consecutive decoded 1s.
- When ones_cnt = 6, the next decoded bit is a stuff bit.
- A stuff bit of 0 SHALL be discarded, with ones_cnt reset to 0.
- A stuff bit of 1 SHALL pulse stuff_err, deassert rx_active and return the FSM to HUNT.
REQ-016 Non-stuff decoded bits SHALL shift into the byte register LSB-first, and bit_cnt SHALL increment modulo 8.
REQ-017 On the 8th bit, rx_data SHALL load the byte and rx_valid SHALL pulse in the cycle after that bit's pop.
REQ-018 rx_data SHALL hold its value until the next byte.
REQ-019 A popped SE0 entry in DATA SHALL move the FSM to EOP and deassert rx_active in the following cycle.
REQ-020 If bit_cnt != 0 at that SE0, the partial byte SHALL be discarded and rx_error SHALL pulse.
REQ-021 In EOP, the first popped non-SE0 entry SHALL return the FSM to HUNT; that entry SHALL be NRZI-decoded and SHALL start a fresh zero run.
REQ-022 All outputs SHALL be registered.
REQ-023 Each output strobe (rx_valid, rx_error, stuff_err, fifo_ovf, fifo_udf) SHALL be exactly one cycle wide per event.

Reset
REQ-024 While reset is high, the block SHALL hold the following state:
- occupancy 0, mode PRIME, FSM HUNT, prev_line 1.
- ones_cnt, bit_cnt and zero run all 0.
- rx_data 8'h00; every other output 0.
REQ-025 The block SHALL accept its first input on the first rising edge at which reset is low.
REQ-026 Reset asserted mid-packet SHALL discard all FIFO contents and the partial byte without pulsing any strobe.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- Line bits KJKJKJKK (K=0, J=1), then the NRZI encoding of 8'hA5, then two SE0 entries, add=drop=0 -> after priming, rx_active=1, one rx_valid with rx_data=8'hA5, then rx_active=0 with no rx_error.
- SYNC, then data 8'hFF with a stuffed 0 after the sixth decoded 1 -> rx_data=8'hFF, stuff bit removed, no stuff_err.
- SYNC, then seven consecutive decoded 1s -> stuff_err pulse, rx_active=0, FSM in HUNT.
- Interleaved add and drop pulses at equal count within one packet carrying 8'h3C -> rx_data=8'h3C, no fifo_ovf or fifo_udf.
- drop held high for DEPTH consecutive cycles while draining -> fifo_udf pulses once, then PRIME until occ=4.
- SYNC, 5 data bits, then SE0 -> rx_error pulse, no rx_valid; reset asserted mid-byte in a repeat run -> all outputs 0 the next cycle.
